// File: rtl/decodificador_barrido.sv
// -----------------------------------------------------------------------------
// decodificador_barrido
//   Registered N-to-2**N one-hot decoder with a global enable and two modes:
//     DIRECT (modo=0): decodes dir on a dir_valida strobe, one cycle latency.
//     SCAN   (modo=1): walks channels 0..ULTIMO, PRESCALER cycles per channel.
//   Intended for display digit/row selects and shared-bus chip selects.
//
// Parameters
//   N          address width, y is 2**N bits wide
//   ULTIMO     highest channel scanned / accepted in direct mode (0..2**N-1)
//   PRESCALER  clock cycles per scan step (>=1)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   global enable, low forces the select inactive
//   modo         in   0 = DIRECT, 1 = SCAN
//   dir          in   [N-1:0] address used in DIRECT mode
//   dir_valida   in   one-cycle strobe qualifying dir
//   y            out  [2**N-1:0] registered one-hot select
//   indice       out  [N-1:0] registered channel currently selected
//   fin_barrido  out  one-cycle pulse when the scan wraps ULTIMO -> 0
//   fuera_rango  out  one-cycle pulse on a strobe with dir > ULTIMO
//
// Build option
//   DEC_SALIDA_BAJA_EN  when defined, y is active-low (bitwise inverse of the
//                       one-hot; all ones when inactive). indice and the
//                       flags are unaffected.
// -----------------------------------------------------------------------------
module decodificador_barrido #(
  parameter int N         = 2,
  parameter int ULTIMO    = (2**N) - 1,
  parameter int PRESCALER = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               modo,
  input  logic [N-1:0]       dir,
  input  logic               dir_valida,
  output logic [(2**N)-1:0]  y,
  output logic [N-1:0]       indice,
  output logic               fin_barrido,
  output logic               fuera_rango
);

  localparam int W  = 2**N;
  localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;

  localparam logic [W-1:0]  ONEHOT_CERO = W'(0);
  localparam logic [W-1:0]  ONEHOT_UNO  = W'(1);
  localparam logic [N-1:0]  IDX_CERO    = N'(0);
  localparam logic [N-1:0]  IDX_UNO     = N'(1);
  localparam logic [N-1:0]  ULTIMO_IDX  = N'(ULTIMO);
  // One bit wider than dir so the range check stays meaningful when
  // ULTIMO is the full 2**N-1.
  localparam logic [N:0]    ULTIMO_EXT  = (N+1)'(ULTIMO);
  localparam logic [PW-1:0] PRESC_CERO  = PW'(0);
  localparam logic [PW-1:0] PRESC_UNO   = PW'(1);
  localparam logic [PW-1:0] PRESC_TC    = PW'(PRESCALER - 1);

  typedef enum logic [1:0] {
    APAGADO = 2'd0,
    DIRECTO = 2'd1,
    BARRIDO = 2'd2
  } estado_t;

  estado_t       estado_r;
  estado_t       estado_sig_s;
  logic [W-1:0]  y_r;
  logic [N-1:0]  indice_r;
  logic [PW-1:0] presc_r;
  logic          fin_barrido_r;
  logic          fuera_rango_r;
  logic [N-1:0]  indice_inc_s;

  // Maps the internal one-hot onto the port polarity; the register holds the
  // port value so y stays a pure flop output in both builds.
  function automatic logic [W-1:0] a_salida(input logic [W-1:0] onehot);
`ifdef DEC_SALIDA_BAJA_EN
    return ~onehot;
`else
    return onehot;
`endif
  endfunction

  // One-hot decode of a channel index.
  function automatic logic [W-1:0] decodifica(input logic [N-1:0] canal);
    return ONEHOT_UNO << canal;
  endfunction

  // Next state follows the mode inputs directly every edge; en low dominates.
  always_comb begin
    estado_sig_s = APAGADO;
    if (!en) begin
      estado_sig_s = APAGADO;
    end else if (modo) begin
      estado_sig_s = BARRIDO;
    end else begin
      estado_sig_s = DIRECTO;
    end
  end

  // Next scan channel when the prescaler reaches terminal count.
  always_comb begin
    indice_inc_s = indice_r + IDX_UNO;
  end

  // State, select, index, prescaler and pulse flags. Actions are chosen by
  // the state being entered, so en/modo/dir_valida sampled on this edge take
  // effect on this edge (one cycle latency).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r      <= APAGADO;
      y_r           <= a_salida(ONEHOT_CERO);
      indice_r      <= IDX_CERO;
      presc_r       <= PRESC_CERO;
      fin_barrido_r <= 1'b0;
      fuera_rango_r <= 1'b0;
    end else begin
      estado_r      <= estado_sig_s;
      fin_barrido_r <= 1'b0;
      fuera_rango_r <= 1'b0;
      case (estado_sig_s)
        APAGADO: begin
          // indice deliberately held so it still reports the last channel.
          y_r     <= a_salida(ONEHOT_CERO);
          presc_r <= PRESC_CERO;
        end
        DIRECTO: begin
          // y/indice hold without a strobe, including after leaving a scan.
          presc_r <= PRESC_CERO;
          if (dir_valida) begin
            if ({1'b0, dir} > ULTIMO_EXT) begin
              y_r           <= a_salida(ONEHOT_CERO);
              fuera_rango_r <= 1'b1;
            end else begin
              y_r      <= a_salida(decodifica(dir));
              indice_r <= dir;
            end
          end else begin
            y_r      <= y_r;
            indice_r <= indice_r;
          end
        end
        BARRIDO: begin
          if (estado_r != BARRIDO) begin
            // Entry edge: channel 0 shown now, then dwells PRESCALER cycles.
            y_r      <= a_salida(ONEHOT_UNO);
            indice_r <= IDX_CERO;
            presc_r  <= PRESC_CERO;
          end else if (presc_r == PRESC_TC) begin
            presc_r <= PRESC_CERO;
            if (indice_r == ULTIMO_IDX) begin
              y_r           <= a_salida(ONEHOT_UNO);
              indice_r      <= IDX_CERO;
              fin_barrido_r <= 1'b1;
            end else begin
              y_r      <= a_salida(decodifica(indice_inc_s));
              indice_r <= indice_inc_s;
            end
          end else begin
            presc_r <= presc_r + PRESC_UNO;
          end
        end
        default: begin
          y_r     <= a_salida(ONEHOT_CERO);
          presc_r <= PRESC_CERO;
        end
      endcase
    end
  end

  assign y           = y_r;
  assign indice      = indice_r;
  assign fin_barrido = fin_barrido_r;
  assign fuera_rango = fuera_rango_r;

endmodule

// File: tb/tb_decodificador_barrido.sv
// -----------------------------------------------------------------------------
// tb_decodificador_barrido
//   Two instances share stimulus: u_dut (N=2, ULTIMO=3, PRESCALER=4) and
//   u_dut2 (N=2, ULTIMO=2, PRESCALER=4). The reference model tracks, per
//   instance, the mode, whether a channel is active, the channel, and the
//   number of cycles elapsed since the scan was entered; scan channel and
//   wrap pulse are derived from that elapsed count arithmetically.
// -----------------------------------------------------------------------------
module tb_decodificador_barrido;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       modo;
  logic [1:0] dir;
  logic       dir_valida;

  logic [3:0] y0, y1;
  logic [1:0] i0, i1;
  logic       f0, f1, r0, r1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = u_dut, 1 = u_dut2.
  int ult[2] = '{3, 2};
  int m_mode[2];   // 0 off, 1 direct, 2 scan
  bit m_act[2];
  int m_idx[2];
  int m_t[2];
  bit m_fin[2];
  bit m_fr[2];

  decodificador_barrido #(.N(2), .ULTIMO(3), .PRESCALER(P)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .modo(modo), .dir(dir),
    .dir_valida(dir_valida), .y(y0), .indice(i0),
    .fin_barrido(f0), .fuera_rango(r0)
  );

  decodificador_barrido #(.N(2), .ULTIMO(2), .PRESCALER(P)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .modo(modo), .dir(dir),
    .dir_valida(dir_valida), .y(y1), .indice(i1),
    .fin_barrido(f1), .fuera_rango(r1)
  );

  always #5 clk = ~clk;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  task automatic modelo_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_act[k] = 1'b0; m_idx[k] = 0; m_t[k] = 0;
      m_fin[k] = 1'b0; m_fr[k] = 1'b0;
    end
  endtask

  task automatic modelo_flanco();
    for (int k = 0; k < 2; k++) begin
      m_fin[k] = 1'b0;
      m_fr[k]  = 1'b0;
      if (!en) begin
        m_mode[k] = 0;
        m_act[k]  = 1'b0;
      end else if (!modo) begin
        if (dir_valida) begin
          if (int'(dir) <= ult[k]) begin
            m_act[k] = 1'b1;
            m_idx[k] = int'(dir);
          end else begin
            m_act[k] = 1'b0;
            m_fr[k]  = 1'b1;
          end
        end
        m_mode[k] = 1;
      end else begin
        bit ya_en_barrido;
        ya_en_barrido = (m_mode[k] == 2);
        m_t[k]   = ya_en_barrido ? m_t[k] + 1 : 0;
        m_idx[k] = (m_t[k] / P) % (ult[k] + 1);
        m_act[k] = 1'b1;
        m_fin[k] = ya_en_barrido && ((m_t[k] % (P * (ult[k] + 1))) == 0);
        m_mode[k] = 2;
      end
    end
  endtask

  function automatic logic [3:0] y_esperado(input int k);
    logic [3:0] v;
    v = m_act[k] ? (4'b0001 << m_idx[k]) : 4'b0000;
`ifdef DEC_SALIDA_BAJA_EN
    v = ~v;
`endif
    return v;
  endfunction

  task automatic verificar();
    chequear("y_u3",      {28'd0, y0}, {28'd0, y_esperado(0)});
    chequear("indice_u3", {30'd0, i0}, m_idx[0]);
    chequear("fin_u3",    {31'd0, f0}, {31'd0, m_fin[0]});
    chequear("fr_u3",     {31'd0, r0}, {31'd0, m_fr[0]});
    chequear("y_u2",      {28'd0, y1}, {28'd0, y_esperado(1)});
    chequear("indice_u2", {30'd0, i1}, m_idx[1]);
    chequear("fin_u2",    {31'd0, f1}, {31'd0, m_fin[1]});
    chequear("fr_u2",     {31'd0, r1}, {31'd0, m_fr[1]});
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later.
  task automatic paso(input logic e, input logic m, input logic [1:0] d, input logic v);
    en = e; modo = m; dir = d; dir_valida = v;
    @(posedge clk);
    modelo_flanco();
    #1;
    verificar();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic reset_asincrono();
    rst_n = 1'b0;
    #1;
    modelo_reset();
    verificar();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic e, m, v;
    rst_n = 1'b0; en = 1'b0; modo = 1'b0; dir = 2'd0; dir_valida = 1'b0;
    modelo_reset();
    #2;
    verificar();
    #10;
    rst_n = 1'b1;

    // Direct decode of channel 2, then held with no strobe.
    paso(1'b1, 1'b0, 2'd2, 1'b1);
    for (int i = 0; i < 10; i++) paso(1'b1, 1'b0, 2'd0, 1'b0);
    paso(1'b1, 1'b0, 2'd1, 1'b1);

    // Scan from entry: covers wraps for both ULTIMO values.
    for (int i = 0; i < 40; i++) paso(1'b1, 1'b1, 2'd3, 1'b1);
    // Back to direct: last scanned channel is held.
    for (int i = 0; i < 3; i++) paso(1'b1, 1'b0, 2'd0, 1'b0);
    // dir=3: valid for ULTIMO=3, out of range for ULTIMO=2.
    paso(1'b1, 1'b0, 2'd3, 1'b1);
    paso(1'b1, 1'b0, 2'd0, 1'b0);
    // en low together with a strobe, then re-enable in direct.
    paso(1'b0, 1'b0, 2'd1, 1'b1);
    paso(1'b1, 1'b0, 2'd0, 1'b0);
    paso(1'b1, 1'b0, 2'd0, 1'b0);
    paso(1'b1, 1'b0, 2'd1, 1'b1);

    // Reset mid-scan with indice at 2.
    for (int i = 0; i < 10; i++) paso(1'b1, 1'b1, 2'd0, 1'b0);
    chequear("pre_reset_idx", {30'd0, i0}, 32'd2);
    reset_asincrono();

    // Randomized traffic.
    m = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) m = ~m;
      v = ($urandom_range(0, 2) == 0);
      paso(e, m, 2'($urandom_range(0, 3)), v);
      if ($urandom_range(0, 499) == 0) reset_asincrono();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
